// File: rtl/bmf_pkg.sv
// Shared constants for the Boolean matrix-factorisation H decoder:
// default sizes, semiring encodings and the reset-time basis.
package bmf_pkg;

   localparam int K_DEF    = 3;   // latent vector width
   localparam int M_DEF    = 4;   // reconstructed word width

   localparam int MODE_OR  = 0;   // OR-of-AND (Boolean semiring)
   localparam int MODE_XOR = 1;   // XOR-of-AND (GF(2))

   // Default 6-bit-adder decode map: po0 = po1 = k0, po2 = k1, po3 = k2.
   localparam logic [K_DEF-1:0][M_DEF-1:0] H_DEFAULT = {4'b1000, 4'b0100, 4'b0011};

endpackage

// File: rtl/bmf_h_decoder_if.sv
// Handshake bundle for the H decoder: basis configuration port, latent
// input stream and reconstructed output stream.
interface bmf_h_decoder_if
   import bmf_pkg::*;
#(
   parameter int K = K_DEF,
   parameter int M = M_DEF
);
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   logic          cfg_we;
   logic [KW-1:0] cfg_row;
   logic [M-1:0]  cfg_data;
   logic          cfg_ready;

   logic          in_valid;
   logic          in_ready;
   logic [K-1:0]  in_k;

   logic          out_valid;
   logic          out_ready;
   logic [M-1:0]  out_po;
   logic [15:0]   out_cnt;

   // Source/sink side: drives config, latent words and output acceptance.
   modport master (
      output cfg_we, cfg_row, cfg_data, in_valid, in_k, out_ready,
      input  cfg_ready, in_ready, out_valid, out_po, out_cnt
   );

   // Decoder side.
   modport slave (
      input  cfg_we, cfg_row, cfg_data, in_valid, in_k, out_ready,
      output cfg_ready, in_ready, out_valid, out_po, out_cnt
   );

endinterface

// File: rtl/bmf_h_product.sv
// Combinational basis product: po[j] = reduce_i (k[i] & h[i][j]), where the
// reduction is OR or XOR depending on the semiring selected by MODE.
module bmf_h_product
   import bmf_pkg::*;
#(
   parameter int K    = K_DEF,
   parameter int M    = M_DEF,
   parameter int MODE = MODE_OR
) (
   input  logic [K-1:0]         k,
   input  logic [K-1:0][M-1:0]  h,
   output logic [M-1:0]         po
);

   for (genvar j = 0; j < M; j++) begin : g_col
      logic [K-1:0] terms;

      for (genvar i = 0; i < K; i++) begin : g_term
         assign terms[i] = k[i] & h[i][j];
      end

      if (MODE == MODE_XOR) begin : g_xor
         assign po[j] = ^terms;
      end else begin : g_or
         assign po[j] = |terms;
      end
   end

endmodule

// File: rtl/bmf_h_decoder.sv
// Two-stage streaming decoder: S1 registers the latent vector, S2 registers
// its product with the K x M basis H. The basis is writable only while the
// pipeline is empty and no word is being offered, so every word sees one basis.
module bmf_h_decoder
   import bmf_pkg::*;
#(
   parameter int K    = K_DEF,
   parameter int M    = M_DEF,
   parameter int MODE = MODE_OR
) (
   input  logic             clk,
   input  logic             rst,
   bmf_h_decoder_if.slave   bus
);

   logic                  s1_valid;
   logic [K-1:0]          s1_k;
   logic                  s2_valid;
   logic [M-1:0]          s2_po;
   logic [15:0]           cnt;
   logic [K-1:0][M-1:0]   h;
   logic [K-1:0][M-1:0]   h_reset;
   logic [M-1:0]          product;
   logic                  s1_adv;
   logic                  in_ready;
   logic                  cfg_ready;
   logic                  cfg_hit;

   // Reset image of the basis: the default map where it fits, zero elsewhere.
   for (genvar i = 0; i < K; i++) begin : g_rst_row
      for (genvar j = 0; j < M; j++) begin : g_rst_col
         if (i < K_DEF && j < M_DEF) begin : g_def
            assign h_reset[i][j] = H_DEFAULT[i][j];
         end else begin : g_zero
            assign h_reset[i][j] = 1'b0;
         end
      end
   end

   // S1 moves whenever S2 is free or being drained this cycle.
   assign s1_adv        = !s2_valid || bus.out_ready;
   assign in_ready      = !s1_valid || s1_adv;
   assign cfg_ready     = !s1_valid && !s2_valid && !bus.in_valid;
   // Rows beyond K do not exist; such writes are dropped.
   assign cfg_hit       = bus.cfg_we && cfg_ready && (int'(bus.cfg_row) < K);

   assign bus.in_ready  = in_ready;
   assign bus.cfg_ready = cfg_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_po    = s2_po;
   assign bus.out_cnt   = cnt;

   bmf_h_product #(
      .K    (K),
      .M    (M),
      .MODE (MODE)
   ) u_product (
      .k  (s1_k),
      .h  (h),
      .po (product)
   );

   // S1: capture a latent vector whenever the stage is free or moving on.
   // NOTE: state is written with <= so every flop samples pre-edge values;
   // blocking assignments here would let S2 see S1's new contents in the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_k     <= '0;
      end else if (in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) s1_k <= bus.in_k;
      end
   end

   // S2: capture the product of S1 with the basis in effect at this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_po    <= '0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_po <= product;
      end
   end

   // Delivered-word counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            cnt <= '0;
      else if (s2_valid && bus.out_ready) cnt <= cnt + 16'd1;
   end

   // Basis register: reloads the default map on reset, one row per accepted write.
   // NOTE: H is a small bank of flops, not a RAM, so resetting it is cheap and
   // guarantees a known decode map after every reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          h <= h_reset;
      else if (cfg_hit) h[bus.cfg_row] <= bus.cfg_data;
   end

endmodule
